axi4_lite_slave_handshake_responder: RTL and testbench

- Slave-side handshake responder directly downstream of the AXI4-Lite master interface.
- Consumes AW/W/AR valids and drives awready/wready/arready with programmable delays.
- Generates B and R responses with programmable latency and bounded outstanding depth.
- Handshake-only: no address/data payload. Serves as the responding endpoint for master-BFM bring-up and as the base for the slave agent BFM.

---
 rtl/axi4_lite_slave_handshake_responder_pkg.sv | 23 ++
 rtl/axi4_lite_slave_handshake_responder_ready_gen.sv | 81 ++++++++
 rtl/axi4_lite_slave_handshake_responder.sv | 157 +++++++++++++++
 tb/tb_axi4_lite_slave_handshake_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_lite_slave_handshake_responder_pkg.sv
// Shared definitions for the AXI4-Lite slave handshake responder.
//   ready_gen_state_e    : state encoding of the per-channel ready generators
//   DEF_*                : default delays, latencies and outstanding depth
//   occ_next()           : next value of an occupancy counter
package Axi4LiteGlobalsPkg;

  typedef enum logic [1:0] {
    RG_IDLE  = 2'd0,
    RG_DELAY = 2'd1,
    RG_READY = 2'd2
  } ready_gen_state_e;

  localparam int DEF_READY_DELAY     = 0;
  localparam int DEF_LATENCY         = 1;
  localparam int DEF_MAX_OUTSTANDING = 4;

  // Accept and retire in the same cycle cancel out. Callers guarantee that a
  // retire only happens with cnt > 0 and an accept only with credit.
  function automatic int occ_next(input int cnt, input logic inc, input logic dec);
    return cnt + int'(inc) - int'(dec);
  endfunction

endpackage

// File: rtl/axi4_lite_slave_handshake_responder_ready_gen.sv
// Ready generator for one AXI4-Lite address/data channel.
//   clk, rst   : clock, synchronous active-high reset
//   valid      : channel valid from the master
//   credit     : room for one more accepted transfer
//   ready      : registered ready, rises DELAY+1 cycles after valid is sampled
//   err_pulse  : valid dropped while waiting for the handshake
module axi4_lite_ready_gen
  import Axi4LiteGlobalsPkg::*;
#(
  parameter int DELAY = DEF_READY_DELAY
) (
  input  logic clk,
  input  logic rst,
  input  logic valid,
  input  logic credit,
  output logic ready,
  output logic err_pulse
);

  // Counter holds DELAY-1 at most; DELAY counts include the IDLE->DELAY edge.
  localparam int TW = (DELAY > 1) ? $clog2(DELAY) : 1;

  ready_gen_state_e state_q, state_d;
  logic [TW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d;

  assign ready     = ready_q;
  assign err_pulse = (state_q != RG_IDLE) && !valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    case (state_q)
      RG_IDLE: begin
        if (valid && credit) begin
          if (DELAY == 0) begin
            state_d = RG_READY;
            ready_d = 1'b1;
          end else begin
            state_d = RG_DELAY;
            cnt_d   = TW'(DELAY - 1);
          end
        end
      end
      RG_DELAY: begin
        if (!valid) begin
          state_d = RG_IDLE;
        end else if (cnt_q == '0) begin
          state_d = RG_READY;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RG_READY: begin
        // ready_q is 1 here, so valid means handshake and !valid means the
        // master gave up; both end the attempt.
        state_d = RG_IDLE;
        ready_d = 1'b0;
      end
      default: begin
        state_d = RG_IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RG_IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/axi4_lite_slave_handshake_responder.sv
// AXI4-Lite slave handshake responder (no payload).
//   aclk, areset          : clock, synchronous active-high reset
//   awvalid/awready       : write address handshake (ready after AW_READY_DELAY)
//   wvalid/wready         : write data handshake (ready after W_READY_DELAY)
//   bvalid/bready         : write response, B_LATENCY after an AW+W pair
//   arvalid/arready       : read address handshake (ready after AR_READY_DELAY)
//   rvalid/rready         : read response, R_LATENCY after an accepted AR
//   wr_outstanding        : accepted AW without completed B
//   rd_outstanding        : accepted AR without completed R
//   protocol_err          : sticky, a valid was dropped before its handshake
module axi4_lite_slave_handshake_responder
  import Axi4LiteGlobalsPkg::*;
#(
  parameter int AW_READY_DELAY  = DEF_READY_DELAY,
  parameter int W_READY_DELAY   = DEF_READY_DELAY,
  parameter int AR_READY_DELAY  = DEF_READY_DELAY,
  parameter int B_LATENCY       = DEF_LATENCY,
  parameter int R_LATENCY       = DEF_LATENCY,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int CW              = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          awvalid,
  output logic          awready,
  input  logic          wvalid,
  output logic          wready,
  output logic          bvalid,
  input  logic          bready,
  input  logic          arvalid,
  output logic          arready,
  output logic          rvalid,
  input  logic          rready,
  output logic [CW-1:0] wr_outstanding,
  output logic [CW-1:0] rd_outstanding,
  output logic          protocol_err
);

  // Timers hold LATENCY-1; a latency of 1 raises valid on the load edge.
  localparam int BTW = (B_LATENCY > 2) ? $clog2(B_LATENCY) : 1;
  localparam int RTW = (R_LATENCY > 2) ? $clog2(R_LATENCY) : 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]  aw_cnt_q, aw_cnt_d, w_cnt_q, w_cnt_d, rd_cnt_q, rd_cnt_d;
  logic           b_pend_q, b_pend_d, bvalid_q, bvalid_d;
  logic           r_pend_q, r_pend_d, rvalid_q, rvalid_d;
  logic [BTW-1:0] b_tmr_q, b_tmr_d;
  logic [RTW-1:0] r_tmr_q, r_tmr_d;
  logic           err_q, err_d;
  logic           aw_err, w_err, ar_err;
  logic           aw_hs, w_hs, ar_hs, b_hs, r_hs;

  axi4_lite_ready_gen #(.DELAY(AW_READY_DELAY)) u_aw_gen (
    .clk(aclk), .rst(areset), .valid(awvalid),
    .credit(aw_cnt_q < MAX_CNT), .ready(awready), .err_pulse(aw_err)
  );

  axi4_lite_ready_gen #(.DELAY(W_READY_DELAY)) u_w_gen (
    .clk(aclk), .rst(areset), .valid(wvalid),
    .credit(w_cnt_q < MAX_CNT), .ready(wready), .err_pulse(w_err)
  );

  axi4_lite_ready_gen #(.DELAY(AR_READY_DELAY)) u_ar_gen (
    .clk(aclk), .rst(areset), .valid(arvalid),
    .credit(rd_cnt_q < MAX_CNT), .ready(arready), .err_pulse(ar_err)
  );

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign ar_hs = arvalid & arready;
  assign b_hs  = bvalid_q & bready;
  assign r_hs  = rvalid_q & rready;

  assign bvalid         = bvalid_q;
  assign rvalid         = rvalid_q;
  assign wr_outstanding = aw_cnt_q;
  assign rd_outstanding = rd_cnt_q;
  assign protocol_err   = err_q;

  always_comb begin
    aw_cnt_d = CW'(occ_next(int'(aw_cnt_q), aw_hs, b_hs));
    w_cnt_d  = CW'(occ_next(int'(w_cnt_q), w_hs, b_hs));
    rd_cnt_d = CW'(occ_next(int'(rd_cnt_q), ar_hs, r_hs));
    err_d    = err_q | aw_err | w_err | ar_err;

    // Write response: one B in flight at a time, started by an AW+W pair.
    b_pend_d = b_pend_q;
    b_tmr_d  = b_tmr_q;
    bvalid_d = bvalid_q;
    if (bvalid_q) begin
      if (bready) bvalid_d = 1'b0;
    end else if (b_pend_q) begin
      if (b_tmr_q <= BTW'(1)) begin
        bvalid_d = 1'b1;
        b_pend_d = 1'b0;
      end else begin
        b_tmr_d = b_tmr_q - 1'b1;
      end
    end else if ((aw_cnt_q != '0) && (w_cnt_q != '0)) begin
      if (B_LATENCY <= 1) begin
        bvalid_d = 1'b1;
      end else begin
        b_pend_d = 1'b1;
        b_tmr_d  = BTW'(B_LATENCY - 1);
      end
    end

    // Read response: same scheme keyed on accepted ARs.
    r_pend_d = r_pend_q;
    r_tmr_d  = r_tmr_q;
    rvalid_d = rvalid_q;
    if (rvalid_q) begin
      if (rready) rvalid_d = 1'b0;
    end else if (r_pend_q) begin
      if (r_tmr_q <= RTW'(1)) begin
        rvalid_d = 1'b1;
        r_pend_d = 1'b0;
      end else begin
        r_tmr_d = r_tmr_q - 1'b1;
      end
    end else if (rd_cnt_q != '0) begin
      if (R_LATENCY <= 1) begin
        rvalid_d = 1'b1;
      end else begin
        r_pend_d = 1'b1;
        r_tmr_d  = RTW'(R_LATENCY - 1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      aw_cnt_q <= '0;
      w_cnt_q  <= '0;
      rd_cnt_q <= '0;
      b_pend_q <= 1'b0;
      b_tmr_q  <= '0;
      bvalid_q <= 1'b0;
      r_pend_q <= 1'b0;
      r_tmr_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      aw_cnt_q <= aw_cnt_d;
      w_cnt_q  <= w_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      b_pend_q <= b_pend_d;
      b_tmr_q  <= b_tmr_d;
      bvalid_q <= bvalid_d;
      r_pend_q <= r_pend_d;
      r_tmr_q  <= r_tmr_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_handshake_responder.sv
// Directed bench: d0 uses default parameters, d1 uses
// AW delay 3, AR delay 2, R latency 3, depth 2.
module tb_axi4_lite_slave_handshake_responder;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic       d0_awvalid, d0_awready, d0_wvalid, d0_wready, d0_bvalid, d0_bready;
  logic       d0_arvalid, d0_arready, d0_rvalid, d0_rready, d0_err;
  logic [2:0] d0_wr_out, d0_rd_out;

  logic       d1_awvalid, d1_awready, d1_wvalid, d1_wready, d1_bvalid, d1_bready;
  logic       d1_arvalid, d1_arready, d1_rvalid, d1_rready, d1_err;
  logic [1:0] d1_wr_out, d1_rd_out;

  axi4_lite_slave_handshake_responder u_d0 (
    .aclk(aclk), .areset(areset),
    .awvalid(d0_awvalid), .awready(d0_awready),
    .wvalid(d0_wvalid), .wready(d0_wready),
    .bvalid(d0_bvalid), .bready(d0_bready),
    .arvalid(d0_arvalid), .arready(d0_arready),
    .rvalid(d0_rvalid), .rready(d0_rready),
    .wr_outstanding(d0_wr_out), .rd_outstanding(d0_rd_out),
    .protocol_err(d0_err)
  );

  axi4_lite_slave_handshake_responder #(
    .AW_READY_DELAY(3), .W_READY_DELAY(0), .AR_READY_DELAY(2),
    .B_LATENCY(1), .R_LATENCY(3), .MAX_OUTSTANDING(2)
  ) u_d1 (
    .aclk(aclk), .areset(areset),
    .awvalid(d1_awvalid), .awready(d1_awready),
    .wvalid(d1_wvalid), .wready(d1_wready),
    .bvalid(d1_bvalid), .bready(d1_bready),
    .arvalid(d1_arvalid), .arready(d1_arready),
    .rvalid(d1_rvalid), .rready(d1_rready),
    .wr_outstanding(d1_wr_out), .rd_outstanding(d1_rd_out),
    .protocol_err(d1_err)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic step_n(input int n);
    repeat (n) step();
  endtask

  initial begin
    int awhs, whs, arhs, maxo, seen;
    areset = 1'b1;
    d0_awvalid = 0; d0_wvalid = 0; d0_bready = 0; d0_arvalid = 0; d0_rready = 0;
    d1_awvalid = 0; d1_wvalid = 0; d1_bready = 0; d1_arvalid = 0; d1_rready = 0;
    step_n(3);
    chk("rst_awready", d0_awready, 0);
    chk("rst_wready", d0_wready, 0);
    chk("rst_arready", d0_arready, 0);
    chk("rst_bvalid", d0_bvalid, 0);
    chk("rst_rvalid", d0_rvalid, 0);
    chk("rst_wr_out", d0_wr_out, 0);
    chk("rst_rd_out", d0_rd_out, 0);
    chk("rst_err", d0_err, 0);
    areset = 1'b0;
    step();

    // Zero delay: AW and W together, B one cycle after the pair is counted.
    d0_awvalid = 1; d0_wvalid = 1;
    step();
    chk("t1_awready", d0_awready, 1);
    chk("t1_wready", d0_wready, 1);
    step();
    chk("t1_awready_drop", d0_awready, 0);
    chk("t1_wready_drop", d0_wready, 0);
    chk("t1_wr_out_1", d0_wr_out, 1);
    chk("t1_bvalid_early", d0_bvalid, 0);
    d0_awvalid = 0; d0_wvalid = 0;
    step();
    chk("t1_bvalid", d0_bvalid, 1);
    d0_bready = 1;
    step();
    chk("t1_bvalid_clr", d0_bvalid, 0);
    chk("t1_wr_out_0", d0_wr_out, 0);
    d0_bready = 0;

    // W leads AW: no B and no outstanding count until AW is accepted.
    d0_wvalid = 1;
    step();
    chk("t3_wready", d0_wready, 1);
    step();
    chk("t3_wr_out_w_only", d0_wr_out, 0);
    d0_wvalid = 0;
    step_n(3);
    chk("t3_bvalid_w_only", d0_bvalid, 0);
    d0_awvalid = 1;
    step();
    chk("t3_awready", d0_awready, 1);
    chk("t3_wr_out_pre", d0_wr_out, 0);
    step();
    chk("t3_wr_out_1", d0_wr_out, 1);
    chk("t3_bvalid_early", d0_bvalid, 0);
    d0_awvalid = 0;
    step();
    chk("t3_bvalid", d0_bvalid, 1);
    d0_bready = 1;
    step();
    chk("t3_bvalid_clr", d0_bvalid, 0);
    chk("t3_wr_out_0", d0_wr_out, 0);
    d0_bready = 0;

    // AR delay 2, R latency 3, rvalid held until rready.
    d1_arvalid = 1;
    step();
    chk("t2_arready_c1", d1_arready, 0);
    step();
    chk("t2_arready_c2", d1_arready, 0);
    step();
    chk("t2_arready_c3", d1_arready, 1);
    step();
    chk("t2_arready_drop", d1_arready, 0);
    chk("t2_rd_out_1", d1_rd_out, 1);
    chk("t2_rvalid_c4", d1_rvalid, 0);
    d1_arvalid = 0;
    step();
    chk("t2_rvalid_c5", d1_rvalid, 0);
    step();
    chk("t2_rvalid_c6", d1_rvalid, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("t2_rvalid_hold", d1_rvalid, 1);
      step();
    end
    chk("t2_rvalid_last", d1_rvalid, 1);
    d1_rready = 1;
    step();
    chk("t2_rvalid_clr", d1_rvalid, 0);
    chk("t2_rd_out_0", d1_rd_out, 0);
    d1_rready = 0;

    // AW delay 3: drop awvalid during DELAY.
    d1_awvalid = 1;
    step();
    chk("t5_awready_delay", d1_awready, 0);
    chk("t5_err_before", d1_err, 0);
    d1_awvalid = 0;
    step();
    chk("t5_err_set", d1_err, 1);
    step_n(3);
    chk("t5_err_sticky", d1_err, 1);
    chk("t5_awready_idle", d1_awready, 0);

    // Depth 2 with bready low: exactly two AW accepted.
    d1_awvalid = 1; d1_wvalid = 1;
    awhs = 0; whs = 0; maxo = 0;
    for (int i = 0; i < 30; i++) begin
      if (d1_awvalid && d1_awready) awhs++;
      if (d1_wvalid && d1_wready) whs++;
      step();
      if (int'(d1_wr_out) > maxo) maxo = int'(d1_wr_out);
    end
    chk("t4_aw_hs", awhs, 2);
    chk("t4_w_hs", whs, 2);
    chk("t4_wr_out_full", d1_wr_out, 2);
    chk("t4_awready_nocredit", d1_awready, 0);
    chk("t4_bvalid", d1_bvalid, 1);
    d1_bready = 1;
    step();
    d1_bready = 0;
    awhs = 0; whs = 0;
    for (int i = 0; i < 12; i++) begin
      if (d1_awvalid && d1_awready) awhs++;
      if (d1_wvalid && d1_wready) whs++;
      step();
      if (int'(d1_wr_out) > maxo) maxo = int'(d1_wr_out);
    end
    chk("t4_third_aw", awhs, 1);
    chk("t4_third_w", whs, 1);
    chk("t4_wr_out_refill", d1_wr_out, 2);
    chk("t4_max_wr_out", maxo, 2);
    chk("t4_bvalid_next", d1_bvalid, 1);
    d1_awvalid = 0; d1_wvalid = 0;

    // Fill the read side to two outstanding with rready low.
    d1_arvalid = 1;
    arhs = 0;
    for (int i = 0; i < 14; i++) begin
      if (d1_arvalid && d1_arready) arhs++;
      step();
    end
    chk("t6_ar_hs", arhs, 2);
    chk("t6_rd_out_2", d1_rd_out, 2);
    chk("t6_rvalid", d1_rvalid, 1);
    chk("t6_arready_nocredit", d1_arready, 0);
    chk("t6_err_still", d1_err, 1);
    d1_arvalid = 0;

    // Reset mid-flight clears everything, nothing emitted afterwards.
    areset = 1'b1;
    step();
    chk("t6_rst_awready", d1_awready, 0);
    chk("t6_rst_wready", d1_wready, 0);
    chk("t6_rst_arready", d1_arready, 0);
    chk("t6_rst_bvalid", d1_bvalid, 0);
    chk("t6_rst_rvalid", d1_rvalid, 0);
    chk("t6_rst_wr_out", d1_wr_out, 0);
    chk("t6_rst_rd_out", d1_rd_out, 0);
    chk("t6_rst_err", d1_err, 0);
    areset = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (d1_bvalid || d1_rvalid || d1_wr_out != 0 || d1_rd_out != 0) seen = 1;
    end
    chk("t6_no_resp_after_rst", seen, 0);
    chk("d0_rd_out_idle", d0_rd_out, 0);
    chk("d0_rvalid_idle", d0_rvalid, 0);
    chk("d0_arready_idle", d0_arready, 0);
    chk("d0_err_clean", d0_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
